window_scheduler: RTL and testbench
===================================

# window_scheduler

Sequencer for the parallel 3x3 filter datapath. It raster-scans every interior pixel of an IMG_W x IMG_H frame and issues one window read per cycle to the window memory. It then asserts the filter `act` strobe once the window data is valid, and produces the write-back strobe and address for each filtered pixel. It replaces the single-signal controller with a stall-aware, latency-tracking pipeline and a start/busy/done handshake.

## Interface
- IMG_W, 64, frame width in pixels (>= 3)
- IMG_H, 64, frame height in pixels (>= 3)
- ADDR_W, 12, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- RD_LAT, 1, cycles from `rd` to window data valid at the filter inputs (>= 1)
- FIL_LAT, 2, cycles from `act` to `cl_pixel` valid (>= 1)

- clk  in  1  single clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- stall  in  1  freeze the whole schedule this cycle
- rd  out  1  issue a window read this cycle
- rd_addr  out  ADDR_W  linear address of the window centre, row*IMG_W+col
- act  out  1  filter-enable strobe for the window issued RD_LAT active cycles earlier
- wr  out  1  write `cl_pixel` back this cycle
- wr_addr  out  ADDR_W  centre address of the pixel being written
- busy  out  1  high in SCAN and DRAIN
- done  out  1  one-cycle pulse at frame completion

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: start=1 goes to SCAN. Row counter is set to 1 and column counter to 1.
  - SCAN: each non-stalled cycle issues one window. Column counts 1..IMG_W-2. On wrap, column returns to 1 and row increments (1..IMG_H-2). After issuing the window at (IMG_H-2, IMG_W-2), go to DRAIN.
  - DRAIN: stay until the pipeline holds no valid entry, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) are never scheduled.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- rd = (state==SCAN) & ~stall. rd_addr is the current counter address. It is held stable while stalled.
- Tracking pipeline: a shift register RD_LAT+FIL_LAT stages deep of {valid, addr}.
  - It advances only when stall=0.
  - Stage 0 loads {rd, rd_addr}.
- act = valid at stage RD_LAT & ~stall.
- wr = valid at stage RD_LAT+FIL_LAT & ~stall. wr_addr is the address at that stage.
- stall=1 has these effects:
  - rd, act and wr are 0.
  - Counters, FSM and pipeline hold.
  - No window is dropped or duplicated.
- start while busy or in DONE is ignored.
- rst=1 at any time, including mid-frame, has these effects at the next edge:
  - FSM goes to IDLE.
  - Counters return to 1.
  - All pipeline valid bits clear.
  - No further rd, act or wr occurs.
- Reset values of outputs: rd=0, act=0, wr=0, busy=0, done=0. rd_addr = IMG_W+1. wr_addr = 0.
- Address arithmetic is unsigned and computed at ADDR_W bits. It never exceeds (IMG_H-2)*IMG_W+IMG_W-2.

## Timing
- start sampled at edge 0. SCAN begins in cycle 1 with the first rd. With no stall, rd is high for cycles 1..N, where N is the window count.
- Let L = RD_LAT+FIL_LAT. act for the window issued in cycle k appears in cycle k+RD_LAT. wr for it appears in cycle k+L. Each additional stall cycle adds exactly one cycle to these distances.
- With no stall:
  - busy is high in cycles 1..N+L.
  - done is high in cycle N+L+1.
  - IDLE resumes in cycle N+L+2.
  - A new start is accepted from cycle N+L+2.
- Default parameters: N=3844, first rd_addr=65, last rd_addr=4030, last wr in cycle 3847, done in cycle 3848.
- Stall during DRAIN holds the pending writes. Stall in the DONE cycle has no effect: done still pulses.

## Test plan
- IMG_W=5, IMG_H=4, no stall, start pulse at cycle 0 -> rd in cycles 1..6 with rd_addr 6,7,8,11,12,13. act in cycles 2..7. wr in cycles 4..9 with the same address sequence. done in cycle 10. busy high in cycles 1..9.
- Same frame with stall=1 in cycles 3 and 4 -> the rd sequence resumes at address 8 in cycle 5. No address is skipped or repeated. wr of 13 occurs in cycle 11 and done in cycle 12.
- start held high continuously -> a frame runs, done pulses, and the next frame starts in the first cycle after returning to IDLE. start in the busy cycles produces no restart.
- rst pulsed in cycle 4 of a frame -> from cycle 5, rd=act=wr=busy=done=0 and FSM is IDLE. A subsequent start replays from address 6.
- IMG_W=3, IMG_H=3 -> exactly one window at address 4: rd in cycle 1, wr in cycle 4, done in cycle 5.
- Default 64x64 frame, random 25% stall -> exactly 3844 rd and 3844 wr events. wr addresses match rd addresses in order. done occurs exactly once.

Source files
------------

// File: rtl/window_scheduler.sv
// Raster-scan sequencer for the 3x3 filter datapath: issues window reads,
// tracks read/filter latency and emits the matching write-back strobes.
module window_scheduler #(
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int ADDR_W  = 12,
   parameter int RD_LAT  = 1,
   parameter int FIL_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   output logic              rd,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              act,
   output logic              wr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done
);

   localparam int L = RD_LAT + FIL_LAT;
   localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(IMG_W + 1);
   localparam logic [ADDR_W-1:0] COL_LAST   = ADDR_W'(IMG_W - 2);
   localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(IMG_H - 2);
   localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ROW_SKIP   = ADDR_W'(3);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] row;
   logic [ADDR_W-1:0] col;
   logic [ADDR_W-1:0] addr;
   logic              last;
   logic [L-1:0]      vld;
   logic [ADDR_W-1:0] pa [L];

   assign last = (row == ROW_LAST) && (col == COL_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Leave DRAIN on the active cycle that writes the last pending pixel
   always_comb begin
      state_nx = state;
      rd       = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = SCAN;
         end
         SCAN: begin
            busy = 1'b1;
            rd   = ~stall;
            if (!stall && last) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!stall && !(|vld[L-2:0])) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Address tracks row*IMG_W+col incrementally; wrap skips the two border columns
   always_ff @(posedge clk) begin
      if (rst || (state == IDLE && start)) begin
         row  <= ONE;
         col  <= ONE;
         addr <= ADDR_FIRST;
      end else if (rd) begin
         if (last) begin
            row  <= ONE;
            col  <= ONE;
            addr <= ADDR_FIRST;
         end else if (col == COL_LAST) begin
            row  <= row + ONE;
            col  <= ONE;
            addr <= addr + ROW_SKIP;
         end else begin
            col  <= col + ONE;
            addr <= addr + ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         for (int i = 0; i < L; i++) pa[i] <= '0;
      end else if (!stall) begin
         vld   <= {vld[L-2:0], rd};
         pa[0] <= addr;
         for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
      end
   end

   assign rd_addr = addr;
   assign act     = vld[RD_LAT-1] & ~stall;
   assign wr      = vld[L-1] & ~stall;
   assign wr_addr = pa[L-1];

endmodule

// File: tb/tb_window_scheduler.sv
// Bench for window_scheduler: three frame geometries driven against a
// cycle-level model built from active-cycle counting.
module tb_window_scheduler;

   localparam int RDL = 1;
   localparam int LAT = 3;
   localparam int WS [3] = '{5, 3, 64};
   localparam int HS [3] = '{4, 3, 64};

   logic        clk;
   logic        rst;
   logic [2:0]  start_v;
   logic [2:0]  stall_v;
   logic [2:0]  rd_v;
   logic [2:0]  act_v;
   logic [2:0]  wr_v;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [11:0] rda_v [3];
   logic [11:0] wra_v [3];

   int errors = 0;
   int checks = 0;

   window_scheduler #(.IMG_W(5), .IMG_H(4)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .stall(stall_v[0]),
      .rd(rd_v[0]), .rd_addr(rda_v[0]), .act(act_v[0]), .wr(wr_v[0]),
      .wr_addr(wra_v[0]), .busy(busy_v[0]), .done(done_v[0])
   );

   window_scheduler #(.IMG_W(3), .IMG_H(3)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .stall(stall_v[1]),
      .rd(rd_v[1]), .rd_addr(rda_v[1]), .act(act_v[1]), .wr(wr_v[1]),
      .wr_addr(wra_v[1]), .busy(busy_v[1]), .done(done_v[1])
   );

   window_scheduler #(.IMG_W(64), .IMG_H(64)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .stall(stall_v[2]),
      .rd(rd_v[2]), .rd_addr(rda_v[2]), .act(act_v[2]), .wr(wr_v[2]),
      .wr_addr(wra_v[2]), .busy(busy_v[2]), .done(done_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle 0 is the cycle carrying start; window j issues in the j-th
   // non-stalled cycle from cycle 1 and lands RDL / LAT active cycles later.
   task automatic run_frame(input string tag, input int s, input int pct,
                            input int sa, input int sb, input bit hold);
      int w, h, n, c, dc, tt, iss, nd, bo;
      int brd, bra, bac, bwr, bwa, bbs, bdn;
      bit b;
      int ac [$];
      bit stl [$];
      int wa [$];
      logic [11:0] rq [$];
      logic [11:0] wq [$];
      bit erd [];
      bit eac [];
      bit ewr [];
      int ewa [];
      w = WS[s];
      h = HS[s];
      n = (w - 2) * (h - 2);
      for (int j = 0; j < n; j++)
         wa.push_back((1 + j / (w - 2)) * w + 1 + j % (w - 2));
      stl.push_back(1'b0);
      c = 1;
      while (ac.size() < n + LAT) begin
         b = (c == sa) || (c == sb) || (int'($urandom_range(99)) < pct);
         stl.push_back(b);
         if (!b) ac.push_back(c);
         c++;
      end
      dc = ac[n+LAT-1] + 1;
      tt = dc + 1;
      while (stl.size() <= tt) begin
         b = int'($urandom_range(99)) < pct;
         stl.push_back(b);
      end
      erd = new[tt+1];
      eac = new[tt+1];
      ewr = new[tt+1];
      ewa = new[tt+1];
      for (int j = 0; j < n; j++) begin
         erd[ac[j]]       = 1'b1;
         eac[ac[j+RDL]]   = 1'b1;
         ewr[ac[j+LAT]]   = 1'b1;
         ewa[ac[j+LAT]]   = wa[j];
      end
      iss = 0; nd = 0;
      brd = 0; bra = 0; bac = 0; bwr = 0; bwa = 0; bbs = 0; bdn = 0;
      for (int cc = 0; cc <= tt; cc++) begin
         start_v[s] = (cc == 0) || hold;
         stall_v[s] = stl[cc];
         @(negedge clk);
         if (rd_v[s] !== erd[cc]) brd++;
         if (cc <= ac[n-1] && rda_v[s] !== 12'(wa[iss])) bra++;
         if (act_v[s] !== eac[cc]) bac++;
         if (wr_v[s] !== ewr[cc]) bwr++;
         if (ewr[cc] && wra_v[s] !== 12'(ewa[cc])) bwa++;
         if (busy_v[s] !== (cc >= 1 && cc < dc)) bbs++;
         if (done_v[s] !== (cc == dc)) bdn++;
         if (rd_v[s] === 1'b1) rq.push_back(rda_v[s]);
         if (wr_v[s] === 1'b1) wq.push_back(wra_v[s]);
         if (done_v[s] === 1'b1) nd++;
         if (erd[cc]) iss++;
         @(posedge clk);
         #1;
      end
      start_v[s] = hold;
      stall_v[s] = 1'b0;
      checks++;
      if (brd !== 0) begin errors++; $display("FAIL %s rd timing: %0d bad cycles, want 0", tag, brd); end
      checks++;
      if (bra !== 0) begin errors++; $display("FAIL %s rd_addr: %0d bad cycles, want 0", tag, bra); end
      checks++;
      if (bac !== 0) begin errors++; $display("FAIL %s act timing: %0d bad cycles, want 0", tag, bac); end
      checks++;
      if (bwr !== 0) begin errors++; $display("FAIL %s wr timing: %0d bad cycles, want 0", tag, bwr); end
      checks++;
      if (bwa !== 0) begin errors++; $display("FAIL %s wr_addr: %0d bad cycles, want 0", tag, bwa); end
      checks++;
      if (bbs !== 0) begin errors++; $display("FAIL %s busy: %0d bad cycles, want 0", tag, bbs); end
      checks++;
      if (bdn !== 0) begin errors++; $display("FAIL %s done timing: %0d bad cycles, want 0 (done cycle %0d)", tag, bdn, dc); end
      checks++;
      if (rq.size() !== n) begin errors++; $display("FAIL %s rd count: got %0d want %0d", tag, rq.size(), n); end
      checks++;
      if (wq.size() !== n) begin errors++; $display("FAIL %s wr count: got %0d want %0d", tag, wq.size(), n); end
      checks++;
      if (nd !== 1) begin errors++; $display("FAIL %s done count: got %0d want 1", tag, nd); end
      bo = 0;
      for (int j = 0; j < n; j++) begin
         if (j >= rq.size() || j >= wq.size()) bo++;
         else if (wq[j] !== rq[j] || rq[j] !== 12'(wa[j])) bo++;
      end
      checks++;
      if (bo !== 0) begin errors++; $display("FAIL %s address order: %0d bad entries, want 0", tag, bo); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_v = '0;
      stall_v = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         checks++;
         if ({rd_v[s], act_v[s], wr_v[s], busy_v[s], done_v[s]} !== 5'b0) begin
            errors++;
            $display("FAIL reset strobes u%0d: got %b want 00000", s,
                     {rd_v[s], act_v[s], wr_v[s], busy_v[s], done_v[s]});
         end
         checks++;
         if (rda_v[s] !== 12'(WS[s] + 1)) begin
            errors++;
            $display("FAIL reset rd_addr u%0d: got %0d want %0d", s, rda_v[s], WS[s] + 1);
         end
         checks++;
         if (wra_v[s] !== 12'd0) begin
            errors++;
            $display("FAIL reset wr_addr u%0d: got %0d want 0", s, wra_v[s]);
         end
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      run_frame("basic5x4", 0, 0, 0, 0, 1'b0);
   endtask

   task automatic test_stall();
      run_frame("stall3_4", 0, 0, 3, 4, 1'b0);
   endtask

   task automatic test_start_held();
      run_frame("start_held", 0, 0, 0, 0, 1'b1);
      @(negedge clk);
      checks++;
      if ({rd_v[0], busy_v[0]} !== 2'b11 || rda_v[0] !== 12'd6) begin
         errors++;
         $display("FAIL restart: rd=%b busy=%b addr=%0d want rd=1 busy=1 addr=6",
                  rd_v[0], busy_v[0], rda_v[0]);
      end
      start_v[0] = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      for (int cc = 0; cc <= 7; cc++) begin
         start_v[0] = (cc == 0);
         rst = (cc == 4);
         @(negedge clk);
         if (cc == 2 && (rd_v[0] !== 1'b1 || rda_v[0] !== 12'd7)) bad++;
         if (cc >= 5) begin
            if ({rd_v[0], act_v[0], wr_v[0], busy_v[0], done_v[0]} !== 5'b0) bad++;
            if (rda_v[0] !== 12'd6) bad++;
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_mid: %0d bad observations, want 0", bad);
      end
      run_frame("after_reset", 0, 0, 0, 0, 1'b0);
   endtask

   task automatic test_tiny();
      run_frame("tiny3x3", 1, 0, 0, 0, 1'b0);
   endtask

   task automatic test_random_small();
      run_frame("rand5x4", 0, 40, 0, 0, 1'b0);
      run_frame("rand3x3", 1, 50, 0, 0, 1'b0);
   endtask

   task automatic test_random_big();
      run_frame("rand64x64", 2, 25, 0, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_start_held();
      test_reset_mid();
      test_tiny();
      test_random_small();
      test_random_big();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
